// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver state encoding and baud divider helper
package uart_pkg;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_BREAK = 3'd4;

  function automatic int uart_div(input int clk_freq_hz, input int baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/receiver_uart_fifo.sv
// rtl/receiver_uart_fifo.sv - first-word-fall-through byte FIFO for the UART receiver
module receiver_uart_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr, rd;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  // A pop frees the slot in the same cycle, so a full FIFO still accepts push+pop.
  assign rd    = pop & ~empty;
  assign wr    = push & (~full | rd);
  assign dout  = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q + AW'(wr);
    rptr_d = rptr_q + AW'(rd);
    cnt_d  = cnt_q + CW'(wr) - CW'(rd);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/receiver_uart.sv
// rtl/receiver_uart.sv - 8N1 UART receiver; RECEIVER_UART_FIFO_EN selects FIFO buffer, else one holding register
module receiver_uart
  import uart_pkg::*;
#(
  parameter int clk_freq_hz = 10_000_000,
  parameter int baud_rate   = 1_000_000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_overrun,
  output logic       o_frame_err,
  input  logic       i_clr_err
);

  localparam int DIV = uart_div(clk_freq_hz, baud_rate);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);

  logic          sync1_q, rx_s_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          ovr_q, ovr_d, ferr_q, ferr_d;
  logic          push, frame_set, overrun_set, pop;
  logic [7:0]    buf_data;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      RX_IDLE: if (!rx_s_q) begin
        cnt_d   = HALF_LOAD;
        state_d = RX_START;
      end
      RX_START: if (cnt_q == '0) begin
        if (rx_s_q) state_d = RX_IDLE;
        else begin
          cnt_d   = FULL_LOAD;
          bit_d   = '0;
          state_d = RX_DATA;
        end
      end else cnt_d = cnt_q - 1'b1;
      RX_DATA: if (cnt_q == '0) begin
        shreg_d = {rx_s_q, shreg_q[7:1]};
        cnt_d   = FULL_LOAD;
        bit_d   = bit_q + 1'b1;
        if (bit_q == 3'd7) state_d = RX_STOP;
      end else cnt_d = cnt_q - 1'b1;
      RX_STOP: if (cnt_q == '0) begin
        if (rx_s_q) begin
          push    = 1'b1;
          state_d = RX_IDLE;
        end else begin
          frame_set = 1'b1;
          state_d   = RX_BREAK;
        end
      end else cnt_d = cnt_q - 1'b1;
      RX_BREAK: if (rx_s_q) state_d = RX_IDLE;
      default: state_d = RX_IDLE;
    endcase
  end

  assign pop = i_ready & o_valid;

`ifdef RECEIVER_UART_FIFO_EN
  logic f_empty, f_full;

  receiver_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .push  (push),
    .din   (shreg_q),
    .pop   (pop),
    .dout  (buf_data),
    .empty (f_empty),
    .full  (f_full)
  );

  assign o_valid     = ~f_empty;
  assign overrun_set = push & f_full & ~pop;
`else
  logic [7:0] hold_q, hold_d;
  logic       hvalid_q, hvalid_d;

  // A push alongside a pop replaces the held byte instead of overrunning.
  always_comb begin
    hold_d   = hold_q;
    hvalid_d = hvalid_q;
    if (push && (!hvalid_q || pop)) begin
      hold_d   = shreg_q;
      hvalid_d = 1'b1;
    end else if (pop) begin
      hvalid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_q   <= '0;
      hvalid_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      hvalid_q <= hvalid_d;
    end
  end

  assign buf_data    = hold_q;
  assign o_valid     = hvalid_q;
  assign overrun_set = push & hvalid_q & ~pop;
`endif

  assign o_data      = o_valid ? buf_data : 8'h00;
  assign ovr_d       = overrun_set | (ovr_q & ~i_clr_err);
  assign ferr_d      = frame_set | (ferr_q & ~i_clr_err);
  assign o_overrun   = ovr_q;
  assign o_frame_err = ferr_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= i_uart_rx;
      rx_s_q  <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

endmodule

// File: tb/tb_receiver_uart.sv
// tb/tb_receiver_uart.sv - self-checking bench for receiver_uart against a byte-queue model
module tb_receiver_uart;

  localparam int DIV = 10;
`ifdef RECEIVER_UART_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_uart_rx = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready = 1'b0;
  logic       o_overrun;
  logic       o_frame_err;
  logic       i_clr_err = 1'b0;

  receiver_uart dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_uart_rx   (i_uart_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_overrun   (o_overrun),
    .o_frame_err (o_frame_err),
    .i_clr_err   (i_clr_err)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] q[$];
  bit exp_ovr = 1'b0;
  bit exp_ferr = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [7:0] ed;
    ed = (q.size() > 0) ? q[0] : 8'h00;
    check({tag, ".valid"}, {7'd0, o_valid}, {7'd0, q.size() > 0});
    check({tag, ".data"}, o_data, ed);
    check({tag, ".overrun"}, {7'd0, o_overrun}, {7'd0, exp_ovr});
    check({tag, ".frame_err"}, {7'd0, o_frame_err}, {7'd0, exp_ferr});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge i_clk);
  endtask

  // Drives one 8N1 frame starting at a falling clock edge; optionally pops exactly
  // on the cycle of the stop-bit sample, then updates the model.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit pop_stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      i_uart_rx = bits[i];
      for (int j = 0; j < DIV; j++) begin
        if (i == 9 && pop_stop) i_ready = (j == 7);
        @(negedge i_clk);
      end
    end
    i_uart_rx = 1'b1;
    i_ready = 1'b0;
    if (pop_stop && q.size() > 0) void'(q.pop_front());
    if (stop) begin
      if (q.size() < DEPTH) q.push_back(b);
      else exp_ovr = 1'b1;
    end else begin
      exp_ferr = 1'b1;
    end
  endtask

  task automatic pop_one();
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic clear_errs();
    i_clr_err = 1'b1;
    @(negedge i_clk);
    i_clr_err = 1'b0;
    exp_ovr = 1'b0;
    exp_ferr = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 1; i++) begin
      check_state(tag);
      pop_one();
    end
    check_state({tag, ".empty"});
  endtask

  initial begin
    vec_t vecs[6];
    vecs[0] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b0};
    vecs[1] = '{8'hA3, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[5] = '{8'h80, 1'b0, 1'b0, 8'h00, 1'b1};

    idle(3);
    check_state("reset");
    i_rst = 1'b0;
    idle(3);
    check_state("after_reset");

    // Short low glitch is rejected as a false start.
    i_uart_rx = 1'b0;
    idle(3);
    i_uart_rx = 1'b1;
    idle(15);
    check_state("glitch");

    foreach (vecs[k]) begin
      send_frame(vecs[k].data, vecs[k].stop, 1'b0);
      if (!vecs[k].stop) begin
        i_uart_rx = 1'b0;
        idle(20);
        i_uart_rx = 1'b1;
      end
      idle(5);
      check($sformatf("vec%0d.valid", k), {7'd0, o_valid}, {7'd0, vecs[k].exp_valid});
      check($sformatf("vec%0d.data", k), o_data, vecs[k].exp_data);
      check($sformatf("vec%0d.ferr", k), {7'd0, o_frame_err}, {7'd0, vecs[k].exp_ferr});
      check_state($sformatf("vec%0d", k));
      pop_one();
      check_state($sformatf("vec%0d.popped", k));
      clear_errs();
      check_state($sformatf("vec%0d.cleared", k));
    end

    for (int b = 8'h10; b <= 8'h14; b++) send_frame(8'(b), 1'b1, 1'b0);
    idle(2);
    check_state("overrun");
    drain("overrun.pop");
    clear_errs();

    for (int b = 8'h20; b <= 8'h23; b++) send_frame(8'(b), 1'b1, 1'b0);
    send_frame(8'h24, 1'b1, 1'b1);
    idle(2);
    check_state("pushpop");
    drain("pushpop.pop");
    clear_errs();

    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      logic stop;
      b = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 7) != 0);
      send_frame(b, stop, $urandom_range(0, 3) == 0);
      idle(stop ? $urandom_range(0, 3) : 6 + $urandom_range(0, 4));
      check_state($sformatf("rand%0d", n));
      for (int p = $urandom_range(0, 2); p > 0; p--) begin
        pop_one();
        check_state($sformatf("rand%0d.pop", n));
      end
      if ($urandom_range(0, 5) == 0) begin
        clear_errs();
        check_state($sformatf("rand%0d.clr", n));
      end
    end
    drain("rand.drain");
    clear_errs();

    // Reset in the middle of data bit 3 with bytes already buffered.
    send_frame(8'h31, 1'b1, 1'b0);
    send_frame(8'h32, 1'b1, 1'b0);
    i_uart_rx = 1'b0;
    idle(DIV);
    i_uart_rx = 1'b1;
    idle(3 * DIV + DIV / 2);
    i_rst = 1'b1;
    #1;
    q.delete();
    exp_ovr = 1'b0;
    exp_ferr = 1'b0;
    check_state("midreset");
    @(negedge i_clk);
    idle(3);
    i_rst = 1'b0;
    idle(2 * DIV);
    check_state("midreset.release");
    send_frame(8'h7E, 1'b1, 1'b0);
    idle(2);
    check_state("after_midreset");
    pop_one();
    check_state("after_midreset.empty");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
